// File: rtl/spi_pkg.sv
// Shared SPI definitions for spi_master and spi_slave_rx.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

    localparam int D_WIDTH_DEFAULT = 16;

    // Link runs in SPI mode 0: sclk idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin with level and edge strobes.
// Latency: SYNC_STAGES clk cycles from pin to level; rise/fall are valid in that same cycle.
// Backpressure: none; edges are single-cycle strobes and cannot be stalled.
module sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Shift the pin through the chain; the history flop holds the previous synchronized value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to the idle level of the pin so no spurious edge appears on release.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receiver with DAC-style holding and ldac-latched output registers.
// Latency: physical cs rise to rx_valid is SYNC_STAGES+1 clk; ldac fall to dac_update likewise.
// Backpressure: none; the master cannot be stalled, errors are flagged by frame_err.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int D_WIDTH     = D_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sclk,
    input  logic               mosi,
    input  logic               cs,
    input  logic               ldac,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               frame_err,
    output logic [D_WIDTH-1:0] dac_out,
    output logic               dac_update,
    output logic               busy
);

    localparam int               CNT_W    = $clog2(D_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(D_WIDTH);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic ldac_lvl, ldac_rise, ldac_fall;
    logic unused_edges;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(clk), .reset(reset), .din(cs), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ldac (
        .clk(clk), .reset(reset), .din(ldac), .level(ldac_lvl), .rise(ldac_rise), .fall(ldac_fall));

    assign unused_edges = ^{sclk_lvl, sclk_fall, mosi_rise, mosi_fall, cs_lvl, ldac_lvl, ldac_rise};

    spi_rx_state_t      state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [D_WIDTH-1:0] shreg_q, shreg_d;
    logic               overrun_q, overrun_d;
    logic [D_WIDTH-1:0] rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [D_WIDTH-1:0] dac_out_q, dac_out_d;
    logic               dac_update_q, dac_update_d;
    logic               busy_q, busy_d;

    // Frame FSM: a coincident sclk_rise is folded in before cs_rise closes the frame.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        overrun_d    = overrun_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        dac_out_d    = dac_out_q;
        dac_update_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    overrun_d = 1'b0;
                    shreg_d   = '0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        overrun_d = 1'b1;
                    end else begin
                        shreg_d   = {shreg_q[D_WIDTH-2:0], mosi_lvl};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                if (cs_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_d == CNT_FULL && !overrun_d) begin
                        rx_data_d  = shreg_d;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // ldac transfers the holding register as it stood before any same-cycle load.
        if (ldac_fall) begin
            dac_out_d    = rx_data_q;
            dac_update_d = 1'b1;
        end

        busy_d = (state_d == SHIFT);
    end

    // State and registered outputs; reset discards any partial frame without pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            overrun_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            dac_out_q    <= '0;
            dac_update_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            overrun_q    <= overrun_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            dac_out_q    <= dac_out_d;
            dac_update_q <= dac_update_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign dac_out    = dac_out_q;
    assign dac_update = dac_update_q;
    assign busy       = busy_q;

endmodule
